// File: rtl/ext_int_ctrl_pkg.sv
// ext_int_ctrl_pkg: register indices, FSM states and bridge base address
// shared by the external interrupt controller and its bench.
package ext_int_ctrl_pkg;
   localparam logic [1:0] EIC_ACK  = 2'd0;
   localparam logic [1:0] EIC_MASK = 2'd1;
   localparam logic [1:0] EIC_PEND = 2'd2;
   localparam logic [1:0] EIC_CFG  = 2'd3;
   localparam logic [31:0] EIC_BASE = 32'h0000_7F20;
   typedef enum logic [1:0] {IDLE, ASSERT, COOLDOWN} eic_state_e;
endpackage

// File: rtl/eic_src_sync.sv
// eic_src_sync: samples raw request lines and produces per-source set pulses.
// EXT_INT_SYNC_EN selects a two-flop synchronizer instead of a single sampling flop.
module eic_src_sync #(
   parameter int NSRC = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] src,
   input  logic [NSRC-1:0] cfg,
   output logic [NSRC-1:0] set
);
   logic [NSRC-1:0] s_q, prev_q;
`ifdef EXT_INT_SYNC_EN
   logic [NSRC-1:0] meta_q;
   always_ff @(posedge clk) begin
      if (!reset) begin
         meta_q <= '0;
         s_q    <= '0;
      end else begin
         meta_q <= src;
         s_q    <= meta_q;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (!reset) s_q <= '0;
      else        s_q <= src;
   end
`endif
   always_ff @(posedge clk) begin
      if (!reset) prev_q <= '0;
      else        prev_q <= s_q;
   end
   // edge-configured bits fire only on a rising edge, the rest follow the level
   assign set = (cfg & s_q & ~prev_q) | (~cfg & s_q);
endmodule

// File: rtl/ext_int_ctrl.sv
// ext_int_ctrl: latches masked device requests into one held CPU interrupt,
// released by an ACK write and followed by a GAP-cycle cooldown (see EXT_INT_SYNC_EN in eic_src_sync).
module ext_int_ctrl
   import ext_int_ctrl_pkg::*;
#(
   parameter int NSRC = 4,
   parameter int GAP  = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] src,
   input  logic [29:0]     Addr,
   input  logic            WE,
   input  logic [31:0]     Din,
   output logic [31:0]     Dout,
   output logic            interrupt
);
   logic [NSRC-1:0] mask_q, cfg_q, pend_q, svc_q, pend_d, set, clr, req;
   eic_state_e      state_q;
   logic            int_q, ack_fire, unused_bits;
   logic [3:0]      cnt_q;
   logic [1:0]      sel;

   eic_src_sync #(.NSRC(NSRC)) u_sync (
      .clk(clk), .reset(reset), .src(src), .cfg(cfg_q), .set(set)
   );

   // Addr is a word address, so its two low bits are byte-address bits [3:2]
   assign sel         = Addr[1:0];
   assign unused_bits = ^{Addr[29:2], Din};
   assign ack_fire    = WE && sel == EIC_ACK && state_q == ASSERT;
   assign clr         = (WE && sel == EIC_PEND ? Din[NSRC-1:0] : '0) | (ack_fire ? svc_q : '0);
   assign pend_d      = (pend_q & ~clr) | set;
   assign req         = pend_q & mask_q;
   assign interrupt   = int_q;

   always_comb begin
      Dout = sel == EIC_ACK  ? {31'b0, int_q} :
             sel == EIC_MASK ? 32'(mask_q) :
             sel == EIC_PEND ? 32'(pend_q) : 32'(cfg_q);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         mask_q  <= '1;
         cfg_q   <= '0;
         pend_q  <= '0;
         svc_q   <= '0;
         state_q <= IDLE;
         int_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         pend_q <= pend_d;
         if (WE && sel == EIC_MASK) mask_q <= Din[NSRC-1:0];
         if (WE && sel == EIC_CFG)  cfg_q  <= Din[NSRC-1:0];
         case (state_q)
            IDLE: if (|req) begin
               state_q <= ASSERT;
               int_q   <= 1'b1;
               svc_q   <= req;
            end
            ASSERT: if (ack_fire) begin
               state_q <= COOLDOWN;
               int_q   <= 1'b0;
               svc_q   <= '0;
               cnt_q   <= 4'(GAP - 1);
            end
            default: if (cnt_q == 4'd0) state_q <= IDLE;
                     else               cnt_q   <= cnt_q - 4'd1;
         endcase
      end
   end
endmodule

// File: tb/tb_ext_int_ctrl.sv
// tb_ext_int_ctrl: scoreboard bench for ext_int_ctrl; expectations are queued with
// each stimulus step and compared against the pin and register reads.
module tb_ext_int_ctrl;
   import ext_int_ctrl_pkg::*;
   localparam int GAP = 2;
   localparam int PIN = 4;
`ifdef EXT_INT_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic        clk = 1'b0, reset = 1'b0, WE = 1'b0, interrupt;
   logic [3:0]  src = '0;
   logic [29:0] Addr = '0;
   logic [31:0] Din = '0, Dout;

   ext_int_ctrl #(.NSRC(4), .GAP(GAP)) dut (
      .clk(clk), .reset(reset), .src(src), .Addr(Addr), .WE(WE),
      .Din(Din), .Dout(Dout), .interrupt(interrupt)
   );

   always #5 clk = ~clk;

   typedef struct {string tag; int sel; logic [31:0] exp;} exp_t;
   exp_t sb[$];
   int   errors = 0, checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_addr(input logic [1:0] idx);
      logic [31:0] a;
      a = EIC_BASE + {28'b0, idx, 2'b00};
      Addr = a[31:2];
   endtask

   task automatic wr(input logic [1:0] idx, input logic [31:0] d);
      set_addr(idx);
      Din = d;
      WE  = 1'b1;
      tick(1);
      WE  = 1'b0;
      Din = '0;
   endtask

   task automatic want(input string tag, input int sel, input logic [31:0] exp);
      sb.push_back('{tag, sel, exp});
   endtask

   task automatic drain();
      exp_t e;
      logic [31:0] obs;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.sel == PIN) obs = {31'b0, interrupt};
         else begin
            set_addr(2'(e.sel));
            #1 obs = Dout;
         end
         check(e.tag, obs, e.exp);
      end
   endtask

   initial begin
      tick(2);
      reset = 1'b1;
      want("rst_int", PIN, 0); want("rst_mask", EIC_MASK, 'hF);
      want("rst_cfg", EIC_CFG, 0); want("rst_pend", EIC_PEND, 0);
      drain();
      want("rst_ack_rd", EIC_ACK, 0); drain();

      // level source, ACK, reassert after cooldown
      src = 4'b0001;
      tick(LAT);
      want("lvl_early", PIN, 0); drain();
      tick(1);
      want("lvl_int", PIN, 1); want("lvl_pend", EIC_PEND, 1); want("lvl_ack_rd", EIC_ACK, 1);
      drain();
      wr(EIC_ACK, 0);
      want("ack_drop", PIN, 0); drain();
      tick(GAP);
      want("gap_hold", PIN, 0); drain();
      tick(1);
      want("gap_reassert", PIN, 1); drain();
      src = '0;
      tick(LAT);
      wr(EIC_ACK, 0);
      wr(EIC_PEND, 'hF);
      tick(GAP + 2);
      want("lvl_clean_pend", EIC_PEND, 0); want("lvl_clean_int", PIN, 0); drain();

      // edge source held high pends only once
      wr(EIC_CFG, 4'b0010);
      src = 4'b0010;
      tick(LAT);
      want("edge_early", PIN, 0); want("cfg_rd", EIC_CFG, 4'b0010); drain();
      tick(1);
      want("edge_int", PIN, 1); want("edge_pend", EIC_PEND, 4'b0010); drain();
      wr(EIC_ACK, 0);
      want("edge_ack_pend", EIC_PEND, 0); want("edge_ack_int", PIN, 0); drain();
      tick(GAP + 3);
      want("edge_held_int", PIN, 0); want("edge_held_pend", EIC_PEND, 0); drain();
      src = '0;
      tick(LAT + 1);

      // masking
      wr(EIC_MASK, 'hE);
      src = 4'b0001;
      tick(LAT + 2);
      want("mask_pend", EIC_PEND, 1); want("mask_int_off", PIN, 0); want("mask_rd", EIC_MASK, 'hE);
      drain();
      wr(EIC_MASK, 'hF);
      want("unmask_early", PIN, 0); drain();
      tick(1);
      want("unmask_int", PIN, 1); drain();
      wr(EIC_MASK, 0);
      want("mask_in_assert", PIN, 1); drain();
      wr(EIC_MASK, 'hF);
      src = '0;
      tick(LAT);
      wr(EIC_ACK, 0);
      wr(EIC_PEND, 'hF);
      tick(GAP + 2);

      // set wins over a simultaneous write-1-clear
      wr(EIC_CFG, 4'b0100);
      src = 4'b0100;
      tick(LAT - 1);
      wr(EIC_PEND, 4'b0100);
      want("set_wins", EIC_PEND, 4'b0100); drain();
      tick(1);
      want("set_wins_int", PIN, 1); drain();
      wr(EIC_PEND, 4'b0100);
      want("w1c_pend", EIC_PEND, 0); want("w1c_int", PIN, 1); drain();
      wr(EIC_ACK, 0);
      src = '0;
      tick(GAP + LAT + 2);
      want("sim_clean_int", PIN, 0); drain();

      // spurious ACK in IDLE is ignored
      wr(EIC_ACK, 0);
      src = 4'b1000;
      want("spur_int", PIN, 0); want("spur_pend", EIC_PEND, 0); drain();
      tick(LAT);
      want("spur_early", PIN, 0); drain();
      tick(1);
      want("spur_lat_int", PIN, 1); drain();

      // reset while asserted
      wr(EIC_MASK, 'h3);
      wr(EIC_CFG, 'hA);
      src   = '0;
      reset = 1'b0;
      tick(1);
      reset = 1'b1;
      want("mid_rst_int", PIN, 0); want("mid_rst_mask", EIC_MASK, 'hF);
      want("mid_rst_cfg", EIC_CFG, 0); want("mid_rst_pend", EIC_PEND, 0);
      drain();
      tick(3);
      want("post_rst_int", PIN, 0); drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
